// File: rtl/udp_rx_word_sink.sv
// Drains the gbe_udp byte-wide receive FIFO, filters frames by source port and packs bytes MSB-first
// into 32-bit words on a valid/ready stream. Define UDP_RX_SINK_STATS_EN to build the frame counters.
module udp_rx_word_sink #(
   parameter logic [15:0] ACCEPT_PORT = 16'hC350,
   parameter bit          PORT_FILTER = 1'b1,
   parameter int unsigned MAX_WORDS   = 256
) (
   input  logic        app_clk,
   input  logic        app_rst_n,
   input  logic [7:0]  app_rx_data,
   input  logic        app_rx_dvld,
   input  logic        app_rx_eof,
   input  logic [31:0] app_rx_srcip,
   input  logic [15:0] app_rx_srcport,
   input  logic        app_rx_badframe,
   input  logic        app_rx_overrun,
   output logic        app_rx_ack,
   output logic [31:0] out_data,
   output logic [2:0]  out_nbytes,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_err,
   output logic [31:0] out_srcip,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] frames_ok,
   output logic [31:0] frames_drop
);

   localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCEPT = 2'd1, DROP = 2'd2} state_t;

   state_t            state, state_d;
   logic [1:0]        idx, idx_d;
   logic [CNT_W-1:0]  word_cnt, word_cnt_d;
   logic              truncated, truncated_d;
   logic              overrun_seen, overrun_seen_d;
   logic [23:0]       asm_q, asm_d;
   logic [31:0]       srcip_q, srcip_d;
   logic [31:0]       out_data_d, out_srcip_d;
   logic [2:0]        out_nbytes_d;
   logic              out_sof_d, out_eof_d, out_err_d, out_valid_d;
   logic              out_free, at_limit, completes;
   logic [31:0]       word_c;

   // Pop decision: a word-completing byte waits until the output register can take it.
   always_comb begin
      out_free   = !out_valid || out_ready;
      at_limit   = (word_cnt == CNT_W'(MAX_WORDS));
      completes  = app_rx_eof || ((idx == 2'd3) && !at_limit);
      app_rx_ack = 1'b0;
      if (app_rx_dvld) begin
         case (state)
            DROP:    app_rx_ack = 1'b1;
            ACCEPT:  app_rx_ack = !completes || out_free;
            default: app_rx_ack = 1'b0;
         endcase
      end
   end

   // Assembled word including the byte at the FIFO head; untouched low bytes are already zero.
   always_comb begin
      case (idx)
         2'd0:    word_c = {app_rx_data, 24'h000000};
         2'd1:    word_c = {asm_q[23:16], app_rx_data, 16'h0000};
         2'd2:    word_c = {asm_q[23:8], app_rx_data, 8'h00};
         default: word_c = {asm_q, app_rx_data};
      endcase
   end

   always_comb begin
      state_d        = state;
      idx_d          = idx;
      word_cnt_d     = word_cnt;
      truncated_d    = truncated;
      overrun_seen_d = overrun_seen | app_rx_overrun;
      asm_d          = asm_q;
      srcip_d        = srcip_q;
      out_data_d     = out_data;
      out_nbytes_d   = out_nbytes;
      out_sof_d      = out_sof;
      out_eof_d      = out_eof;
      out_err_d      = out_err;
      out_srcip_d    = out_srcip;
      out_valid_d    = out_valid && !out_ready;
      case (state)
         IDLE: begin
            idx_d       = 2'd0;
            word_cnt_d  = '0;
            truncated_d = 1'b0;
            asm_d       = '0;
            if (app_rx_dvld) begin
               if (!PORT_FILTER || (app_rx_srcport == ACCEPT_PORT)) begin
                  state_d = ACCEPT;
                  srcip_d = app_rx_srcip;
               end else begin
                  state_d = DROP;
               end
            end
         end
         ACCEPT: begin
            if (app_rx_ack) begin
               if (at_limit && !app_rx_eof) begin
                  truncated_d = 1'b1;
               end else if (completes) begin
                  // An eof byte arriving at the word limit still yields a 1-byte word, flagged bad.
                  out_data_d   = word_c;
                  out_nbytes_d = 3'(idx) + 3'd1;
                  out_sof_d    = (word_cnt == '0);
                  out_eof_d    = app_rx_eof;
                  out_err_d    = app_rx_eof && (app_rx_badframe || truncated || at_limit ||
                                                overrun_seen || app_rx_overrun);
                  out_srcip_d  = srcip_q;
                  out_valid_d  = 1'b1;
                  idx_d        = 2'd0;
                  asm_d        = '0;
                  if (!at_limit) word_cnt_d = word_cnt + CNT_W'(1);
                  if (app_rx_eof) begin
                     state_d        = IDLE;
                     overrun_seen_d = 1'b0;
                  end
               end else begin
                  case (idx)
                     2'd0:    asm_d[23:16] = app_rx_data;
                     2'd1:    asm_d[15:8]  = app_rx_data;
                     default: asm_d[7:0]   = app_rx_data;
                  endcase
                  idx_d = idx + 2'd1;
               end
            end
         end
         DROP: begin
            if (app_rx_ack && app_rx_eof) begin
               state_d        = IDLE;
               overrun_seen_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) state <= IDLE;
      else            state <= state_d;
   end

   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) begin
         idx          <= 2'd0;
         word_cnt     <= '0;
         truncated    <= 1'b0;
         overrun_seen <= 1'b0;
         asm_q        <= '0;
         srcip_q      <= '0;
         out_data     <= '0;
         out_nbytes   <= '0;
         out_sof      <= 1'b0;
         out_eof      <= 1'b0;
         out_err      <= 1'b0;
         out_srcip    <= '0;
         out_valid    <= 1'b0;
      end else begin
         idx          <= idx_d;
         word_cnt     <= word_cnt_d;
         truncated    <= truncated_d;
         overrun_seen <= overrun_seen_d;
         asm_q        <= asm_d;
         srcip_q      <= srcip_d;
         out_data     <= out_data_d;
         out_nbytes   <= out_nbytes_d;
         out_sof      <= out_sof_d;
         out_eof      <= out_eof_d;
         out_err      <= out_err_d;
         out_srcip    <= out_srcip_d;
         out_valid    <= out_valid_d;
      end
   end

`ifdef UDP_RX_SINK_STATS_EN
   logic ok_done, drop_done;

   assign ok_done   = out_valid && out_ready && out_eof && !out_err;
   assign drop_done = (state == DROP) && app_rx_ack && app_rx_eof;

   // Saturating frame counters.
   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) begin
         frames_ok   <= '0;
         frames_drop <= '0;
      end else begin
         if (ok_done && (frames_ok != 32'hFFFF_FFFF))     frames_ok   <= frames_ok + 32'd1;
         if (drop_done && (frames_drop != 32'hFFFF_FFFF)) frames_drop <= frames_drop + 32'd1;
      end
   end
`else
   assign frames_ok   = '0;
   assign frames_drop = '0;
`endif

endmodule

// File: tb/tb_udp_rx_word_sink.sv
// Bench for udp_rx_word_sink: three instances (default, no port filter, MAX_WORDS=2) fed identical
// frame streams, each checked against a frame-level word model.
module tb_udp_rx_word_sink;

   localparam int ND = 3;
`ifdef UDP_RX_SINK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [7:0]  data;
      logic        eof;
      logic        bad;
      logic [31:0] ip;
      logic [15:0] port;
   } src_t;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  nb;
      logic        sof;
      logic        eof;
      logic        err;
      logic [31:0] ip;
   } word_t;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ready, overrun;
   logic [7:0]  rx_data [ND];
   logic        rx_dvld [ND], rx_eof [ND], rx_bad [ND];
   logic [31:0] rx_ip [ND];
   logic [15:0] rx_port [ND];
   logic        ack [ND];
   logic [31:0] o_data [ND], o_ip [ND], f_ok [ND], f_drop [ND];
   logic [2:0]  o_nb [ND];
   logic        o_sof [ND], o_eof [ND], o_err [ND], o_valid [ND];

   src_t  src_q [ND][$];
   word_t exp_q [ND][$];
   word_t got_q [ND][$];
   int    exp_ok [ND], exp_drop [ND], pop_cnt [ND];
   logic  will_pop [ND];
   int    ack_viol = 0;
   int    n_chk = 0, n_fail = 0;

   udp_rx_word_sink #(.PORT_FILTER(1'b1), .MAX_WORDS(256)) dut_a (
      .app_clk(clk), .app_rst_n(rst_n), .app_rx_data(rx_data[0]), .app_rx_dvld(rx_dvld[0]),
      .app_rx_eof(rx_eof[0]), .app_rx_srcip(rx_ip[0]), .app_rx_srcport(rx_port[0]),
      .app_rx_badframe(rx_bad[0]), .app_rx_overrun(overrun), .app_rx_ack(ack[0]),
      .out_data(o_data[0]), .out_nbytes(o_nb[0]), .out_sof(o_sof[0]), .out_eof(o_eof[0]),
      .out_err(o_err[0]), .out_srcip(o_ip[0]), .out_valid(o_valid[0]), .out_ready(ready),
      .frames_ok(f_ok[0]), .frames_drop(f_drop[0]));

   udp_rx_word_sink #(.PORT_FILTER(1'b0), .MAX_WORDS(256)) dut_b (
      .app_clk(clk), .app_rst_n(rst_n), .app_rx_data(rx_data[1]), .app_rx_dvld(rx_dvld[1]),
      .app_rx_eof(rx_eof[1]), .app_rx_srcip(rx_ip[1]), .app_rx_srcport(rx_port[1]),
      .app_rx_badframe(rx_bad[1]), .app_rx_overrun(overrun), .app_rx_ack(ack[1]),
      .out_data(o_data[1]), .out_nbytes(o_nb[1]), .out_sof(o_sof[1]), .out_eof(o_eof[1]),
      .out_err(o_err[1]), .out_srcip(o_ip[1]), .out_valid(o_valid[1]), .out_ready(ready),
      .frames_ok(f_ok[1]), .frames_drop(f_drop[1]));

   udp_rx_word_sink #(.PORT_FILTER(1'b1), .MAX_WORDS(2)) dut_c (
      .app_clk(clk), .app_rst_n(rst_n), .app_rx_data(rx_data[2]), .app_rx_dvld(rx_dvld[2]),
      .app_rx_eof(rx_eof[2]), .app_rx_srcip(rx_ip[2]), .app_rx_srcport(rx_port[2]),
      .app_rx_badframe(rx_bad[2]), .app_rx_overrun(overrun), .app_rx_ack(ack[2]),
      .out_data(o_data[2]), .out_nbytes(o_nb[2]), .out_sof(o_sof[2]), .out_eof(o_eof[2]),
      .out_err(o_err[2]), .out_srcip(o_ip[2]), .out_valid(o_valid[2]), .out_ready(ready),
      .frames_ok(f_ok[2]), .frames_drop(f_drop[2]));

   // FWFT source per instance plus output monitor: sample at negedge, pop/present just after posedge.
   initial begin
      for (int d = 0; d < ND; d++) begin
         rx_data[d] = 8'h00; rx_dvld[d] = 1'b0; rx_eof[d] = 1'b0; rx_bad[d] = 1'b0;
         rx_ip[d] = 32'h0; rx_port[d] = 16'h0; pop_cnt[d] = 0; will_pop[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            will_pop[d] = ack[d];
            if (ack[d]) begin
               pop_cnt[d]++;
               if (!rx_dvld[d]) ack_viol++;
            end
            if (o_valid[d] && ready)
               got_q[d].push_back('{o_data[d], o_nb[d], o_sof[d], o_eof[d], o_err[d], o_ip[d]});
         end
         @(posedge clk);
         #1;
         for (int d = 0; d < ND; d++) begin
            if (will_pop[d] && src_q[d].size() > 0) void'(src_q[d].pop_front());
            if (src_q[d].size() > 0) begin
               rx_data[d] = src_q[d][0].data;
               rx_dvld[d] = 1'b1;
               rx_eof[d]  = src_q[d][0].eof;
               rx_bad[d]  = src_q[d][0].bad && src_q[d][0].eof;
               rx_ip[d]   = src_q[d][0].ip;
               rx_port[d] = src_q[d][0].port;
            end else begin
               rx_data[d] = 8'h00; rx_dvld[d] = 1'b0; rx_eof[d] = 1'b0; rx_bad[d] = 1'b0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic bq_t seq_bytes(input int start, input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'(start + i));
      return q;
   endfunction

   // Expected words for one frame: 4-byte chunks, at most mw words, overflow ends in a 1-byte bad word.
   task automatic model_frame(input int d, input logic [15:0] port, input logic [31:0] ip,
                              input bq_t b, input logic bad, input logic ovr);
      int mw, n, nw, cnt;
      word_t w;
      logic [31:0] acc;
      if (d != 1 && port != 16'hC350) begin
         exp_drop[d]++;
         return;
      end
      mw = (d == 2) ? 2 : 256;
      n  = b.size();
      nw = (n > 4 * mw) ? mw : (n + 3) / 4;
      for (int i = 0; i < nw; i++) begin
         cnt = (n - 4 * i >= 4) ? 4 : n - 4 * i;
         acc = 32'h0;
         for (int j = 0; j < cnt; j++) acc[31 - 8 * j -: 8] = b[4 * i + j];
         w.data = acc; w.nb = 3'(cnt); w.sof = (i == 0); w.ip = ip;
         w.eof  = (n <= 4 * mw) && (i == nw - 1);
         w.err  = w.eof && (bad || ovr);
         exp_q[d].push_back(w);
         if (w.eof && !w.err) exp_ok[d]++;
      end
      if (n > 4 * mw) begin
         w.data = {b[n - 1], 24'h0}; w.nb = 3'd1; w.sof = 1'b0; w.eof = 1'b1; w.err = 1'b1; w.ip = ip;
         exp_q[d].push_back(w);
      end
   endtask

   task automatic send_frame(input logic [15:0] port, input logic [31:0] ip, input bq_t b,
                             input logic bad, input logic ovr);
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < b.size(); i++)
            src_q[d].push_back('{b[i], (i == b.size() - 1), bad, ip, port});
         model_frame(d, port, ip, b, bad, ovr);
      end
   endtask

   function automatic bit all_idle();
      for (int d = 0; d < ND; d++)
         if (src_q[d].size() != 0 || rx_dvld[d] || o_valid[d]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input string name);
      int t = 0;
      ready = 1'b1;
      while (!all_idle() && t < 2000) begin
         tick(1);
         t++;
      end
      n_chk++;
      if (!all_idle()) begin
         n_fail++;
         $display("FAIL %s_timeout still busy after %0d cycles, required idle", name, t);
      end
      tick(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ready = 1'b1; overrun = 1'b0;
      for (int d = 0; d < ND; d++) begin exp_ok[d] = 0; exp_drop[d] = 0; end
      tick(3);
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if ({o_valid[d], o_data[d], o_nb[d], o_sof[d], o_eof[d], o_err[d], o_ip[d],
              f_ok[d], f_drop[d], ack[d]} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d valid=%b data=%h nb=%0d ok=%0d drop=%0d ack=%b, required all 0",
                     d, o_valid[d], o_data[d], o_nb[d], f_ok[d], f_drop[d], ack[d]);
         end
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_basic();
      word_t g, e;
      send_frame(16'hC350, 32'h0A00_0001, seq_bytes(1, 8), 1'b0, 1'b0);
      send_frame(16'hC350, 32'h0A00_0002, seq_bytes(8'hAA, 6), 1'b0, 1'b0);
      drain("basic");
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (got_q[d].size() !== exp_q[d].size()) begin
            n_fail++;
            $display("FAIL basic_count dut%0d got %0d words, required %0d", d, got_q[d].size(), exp_q[d].size());
         end
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL basic_word dut%0d got %h, required %h", d, g, e); end
         end
         got_q[d].delete(); exp_q[d].delete();
         n_chk++;
         if (f_ok[d] !== (STATS ? 32'(exp_ok[d]) : 32'h0)) begin
            n_fail++; $display("FAIL basic_frames_ok dut%0d got %0d, required %0d", d, f_ok[d], exp_ok[d]);
         end
      end
   endtask

   task automatic test_filter();
      word_t g, e;
      int base [ND];
      for (int d = 0; d < ND; d++) base[d] = pop_cnt[d];
      send_frame(16'h1234, 32'hC0A8_0005, seq_bytes(8'h50, 5), 1'b0, 1'b0);
      drain("filter");
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (pop_cnt[d] - base[d] !== 5) begin
            n_fail++; $display("FAIL filter_acks dut%0d got %0d, required 5", d, pop_cnt[d] - base[d]);
         end
         n_chk++;
         if (got_q[d].size() !== exp_q[d].size()) begin
            n_fail++;
            $display("FAIL filter_count dut%0d got %0d words, required %0d", d, got_q[d].size(), exp_q[d].size());
         end
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL filter_word dut%0d got %h, required %h", d, g, e); end
         end
         got_q[d].delete(); exp_q[d].delete();
         n_chk++;
         if (f_drop[d] !== (STATS ? 32'(exp_drop[d]) : 32'h0)) begin
            n_fail++; $display("FAIL filter_frames_drop dut%0d got %0d, required %0d", d, f_drop[d], exp_drop[d]);
         end
      end
   endtask

   task automatic test_backpressure();
      word_t g, e;
      int base [ND];
      for (int d = 0; d < ND; d++) base[d] = pop_cnt[d];
      ready = 1'b0;
      send_frame(16'hC350, 32'h0A00_0003, seq_bytes(1, 12), 1'b0, 1'b0);
      tick(12);
      for (int i = 0; i < 2; i++) begin
         for (int d = 0; d < ND; d++) begin
            n_chk++;
            if (pop_cnt[d] - base[d] !== 7 || o_valid[d] !== 1'b1 || o_data[d] !== 32'h0102_0304) begin
               n_fail++;
               $display("FAIL stall_hold dut%0d pops=%0d valid=%b data=%h, required 7/1/01020304",
                        d, pop_cnt[d] - base[d], o_valid[d], o_data[d]);
            end
         end
         tick(3);
      end
      drain("stall");
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (got_q[d].size() !== exp_q[d].size()) begin
            n_fail++;
            $display("FAIL stall_count dut%0d got %0d words, required %0d", d, got_q[d].size(), exp_q[d].size());
         end
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL stall_word dut%0d got %h, required %h", d, g, e); end
         end
         got_q[d].delete(); exp_q[d].delete();
      end
   endtask

   task automatic test_limits();
      word_t g, e;
      send_frame(16'hC350, 32'h0A00_0004, seq_bytes(8'h10, 12), 1'b0, 1'b0);
      send_frame(16'hC350, 32'h0A00_0005, seq_bytes(8'h20, 8), 1'b0, 1'b0);
      send_frame(16'hC350, 32'h0A00_0006, seq_bytes(8'h30, 9), 1'b0, 1'b0);
      send_frame(16'hC350, 32'h0A00_0007, seq_bytes(8'h40, 4), 1'b1, 1'b0);
      send_frame(16'hC350, 32'h0A00_0008, seq_bytes(8'h7E, 1), 1'b0, 1'b0);
      drain("limits");
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (got_q[d].size() !== exp_q[d].size()) begin
            n_fail++;
            $display("FAIL limits_count dut%0d got %0d words, required %0d", d, got_q[d].size(), exp_q[d].size());
         end
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL limits_word dut%0d got %h, required %h", d, g, e); end
         end
         got_q[d].delete(); exp_q[d].delete();
         n_chk++;
         if (f_ok[d] !== (STATS ? 32'(exp_ok[d]) : 32'h0)) begin
            n_fail++; $display("FAIL limits_frames_ok dut%0d got %0d, required %0d", d, f_ok[d], exp_ok[d]);
         end
      end
   endtask

   task automatic test_overrun();
      word_t g, e;
      send_frame(16'hC350, 32'h0A00_0009, seq_bytes(8'h60, 12), 1'b0, 1'b1);
      tick(4);
      overrun = 1'b1;
      tick(1);
      overrun = 1'b0;
      drain("overrun_a");
      send_frame(16'hC350, 32'h0A00_000A, seq_bytes(8'h70, 5), 1'b0, 1'b0);
      drain("overrun_b");
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (got_q[d].size() !== exp_q[d].size()) begin
            n_fail++;
            $display("FAIL overrun_count dut%0d got %0d words, required %0d", d, got_q[d].size(), exp_q[d].size());
         end
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL overrun_word dut%0d got %h, required %h", d, g, e); end
         end
         got_q[d].delete(); exp_q[d].delete();
      end
   endtask

   task automatic test_back_to_back();
      word_t g, e;
      int base [ND];
      for (int d = 0; d < ND; d++) base[d] = pop_cnt[d];
      send_frame(16'hC350, 32'h0A00_000B, seq_bytes(8'h80, 4), 1'b0, 1'b0);
      send_frame(16'hC350, 32'h0A00_000C, seq_bytes(8'h90, 5), 1'b0, 1'b0);
      tick(11);
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (pop_cnt[d] - base[d] !== 8) begin
            n_fail++; $display("FAIL b2b_gap dut%0d got %0d pops, required 8", d, pop_cnt[d] - base[d]);
         end
      end
      tick(1);
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (pop_cnt[d] - base[d] !== 9) begin
            n_fail++; $display("FAIL b2b_total dut%0d got %0d pops, required 9", d, pop_cnt[d] - base[d]);
         end
      end
      drain("b2b");
      for (int d = 0; d < ND; d++) begin
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL b2b_word dut%0d got %h, required %h", d, g, e); end
         end
         n_chk++;
         if (got_q[d].size() + exp_q[d].size() !== 0) begin
            n_fail++; $display("FAIL b2b_count dut%0d leftover got=%0d expected=%0d, required 0",
                               d, got_q[d].size(), exp_q[d].size());
         end
         got_q[d].delete(); exp_q[d].delete();
      end
   endtask

   task automatic test_random();
      word_t g, e;
      bq_t b;
      int t = 0;
      for (int f = 0; f < 30; f++) begin
         b = {};
         for (int i = 0; i < $urandom_range(1, 14); i++) b.push_back(8'($urandom));
         send_frame(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hC350, $urandom, b,
                    ($urandom_range(0, 4) == 0), 1'b0);
      end
      while (!all_idle() && t < 3000) begin
         ready = ($urandom_range(0, 3) != 0);
         tick(1);
         t++;
      end
      drain("random");
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (got_q[d].size() !== exp_q[d].size()) begin
            n_fail++;
            $display("FAIL random_count dut%0d got %0d words, required %0d", d, got_q[d].size(), exp_q[d].size());
         end
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL random_word dut%0d got %h, required %h", d, g, e); end
         end
         got_q[d].delete(); exp_q[d].delete();
         n_chk++;
         if (f_ok[d] !== (STATS ? 32'(exp_ok[d]) : 32'h0) || f_drop[d] !== (STATS ? 32'(exp_drop[d]) : 32'h0)) begin
            n_fail++;
            $display("FAIL random_counters dut%0d got ok=%0d drop=%0d, required ok=%0d drop=%0d",
                     d, f_ok[d], f_drop[d], exp_ok[d], exp_drop[d]);
         end
      end
      n_chk++;
      if (ack_viol !== 0) begin
         n_fail++; $display("FAIL ack_without_dvld got %0d occurrences, required 0", ack_viol);
      end
   endtask

   task automatic test_mid_reset();
      word_t g, e;
      send_frame(16'hC350, 32'h0A00_000D, seq_bytes(8'hA0, 10), 1'b0, 1'b0);
      tick(4);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if ({o_valid[d], o_data[d], o_nb[d], o_sof[d], o_eof[d], o_err[d], o_ip[d],
              f_ok[d], f_drop[d], ack[d]} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs dut%0d valid=%b data=%h ok=%0d ack=%b, required all 0",
                     d, o_valid[d], o_data[d], f_ok[d], ack[d]);
         end
         src_q[d].delete(); got_q[d].delete(); exp_q[d].delete();
         exp_ok[d] = 0; exp_drop[d] = 0;
      end
      tick(2);
      rst_n = 1'b1;
      tick(2);
      send_frame(16'hC350, 32'h0A00_000E, seq_bytes(8'hB0, 5), 1'b0, 1'b0);
      drain("midreset");
      for (int d = 0; d < ND; d++) begin
         n_chk++;
         if (got_q[d].size() !== exp_q[d].size()) begin
            n_fail++;
            $display("FAIL midreset_count dut%0d got %0d words, required %0d", d, got_q[d].size(), exp_q[d].size());
         end
         while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
            g = got_q[d].pop_front(); e = exp_q[d].pop_front(); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL midreset_word dut%0d got %h, required %h", d, g, e); end
         end
         n_chk++;
         if (f_ok[d] !== (STATS ? 32'(exp_ok[d]) : 32'h0)) begin
            n_fail++; $display("FAIL midreset_frames_ok dut%0d got %0d, required %0d", d, f_ok[d], exp_ok[d]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filter();
      test_backpressure();
      test_limits();
      test_overrun();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_rx_word_sink.md
Name: udp_rx_word_sink

Overview:
- Application-side consumer of the gbe_udp receive interface. Drains the byte-wide app_rx stream using app_rx_ack.
- Filters frames by UDP source port and packs bytes MSB-first into 32-bit words.
- Presents words on a valid/ready stream with sof/eof/error tags. Sits between the UDP core and the downstream command/readout logic.

Parameters:
- ACCEPT_PORT, 16'hC350, required app_rx_srcport. Non-matching frames are drained and dropped.
- PORT_FILTER, 1, 0 = accept every port.
- MAX_WORDS, 256, maximum output words per frame. Further bytes are dropped and the frame is flagged truncated.

Ports:
- app_clk  in  1  single clock
- app_rst_n  in  1  asynchronous active-low reset
- app_rx_data  in  8  head byte of rx FIFO (first-word-fall-through)
- app_rx_dvld  in  1  head byte valid
- app_rx_eof  in  1  head byte is last of frame
- app_rx_srcip  in  32  source IP, stable for whole frame
- app_rx_srcport  in  16  source port, stable for whole frame
- app_rx_badframe  in  1  frame bad, valid together with eof byte
- app_rx_overrun  in  1  core rx overrun (level)
- app_rx_ack  out  1  pop head byte this cycle
- out_data  out  32  packed word, first byte in [31:24]
- out_nbytes  out  3  valid bytes in out_data, 1..4
- out_sof  out  1  first word of frame
- out_eof  out  1  last word of frame
- out_err  out  1  on eof word: badframe, truncated or overrun seen
- out_srcip  out  32  srcip latched at frame start
- out_valid  out  1  word valid
- out_ready  in  1  consumer accepts word
- frames_ok  out  32  see Optional Feature
- frames_drop  out  32  see Optional Feature

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index 0.
- app_rx_ack is combinational: app_rx_dvld AND (state==DROP OR the current byte does not complete a word OR the output register is free). "Free" means out_valid==0 or out_ready==1 in the same cycle.
- Exactly one byte is popped per acked cycle. app_rx_ack is never asserted while app_rx_dvld==0.
- States:
  - IDLE: on app_rx_dvld, evaluate the port filter without popping. Go to ACCEPT if PORT_FILTER==0 or app_rx_srcport==ACCEPT_PORT, else go to DROP. Latch srcip on entry to ACCEPT.
  - ACCEPT: shift each popped byte into the assembly register at index 0..3.
    - At index 3, or on an eof byte, load the output register: nbytes = index+1, unused low bytes zero, sof set on the frame's first word, eof set on the eof byte.
    - Word count increments per loaded word. Once it reaches MAX_WORDS, non-eof bytes are popped and discarded, and the truncated flag is set.
    - If the truncation limit is hit before eof, the eof byte produces a 1-byte eof word with err=1, so the eof word is always emitted.
    - On the eof byte, err = app_rx_badframe OR truncated OR overrun_seen. Return to IDLE.
  - DROP: pop every byte. On the eof byte, return to IDLE and increment frames_drop.
- overrun_seen: sticky per frame. Set by app_rx_overrun in any state. Cleared on entry to IDLE.
- Output register: holds out_data, out_nbytes, out_sof, out_eof and out_err stable while out_valid && !out_ready.
- Latency: 1 cycle from the acking of a word's last byte to out_valid.
- Back-to-back frames: IDLE is occupied for exactly 1 cycle between frames, with no pop in that cycle.
- A frame with 0 payload bytes cannot occur (eof always rides on a byte).
- frames_ok increments when an eof word is accepted with err==0. Counters saturate at 32'hFFFFFFFF.
- Reset mid-frame: the partial word is discarded and the FSM returns to IDLE. The remainder of the interrupted frame is then treated as a new frame (the upstream core is reset in the same domain).

Optional Feature:
- Macro UDP_RX_SINK_STATS_EN.
- Defined: frames_ok and frames_drop counters are implemented as specified.
- Undefined: both outputs are tied to 0 and the counter registers are omitted. All other behaviour is identical.

Test Plan:
- Send 8-byte frame 01..08 from port C350, out_ready=1 -> two words 01020304 (sof, nbytes=4) and 05060708 (eof, nbytes=4, err=0); frames_ok=1.
- Send 6-byte frame AA..FF -> words AABBCCDD then EEFF0000 with nbytes=2, eof=1.
- Send 5-byte frame from port 1234 with PORT_FILTER=1 -> 5 acks, no out_valid, frames_drop=1. Repeat with PORT_FILTER=0 -> frame is emitted.
- Hold out_ready=0 for 10 cycles during a 12-byte frame -> ack stalls on the 8th byte; out_data stays stable; all 3 words arrive in order after release.
- With MAX_WORDS=2, send a 12-byte frame -> 2 words, then a 1-byte eof word with err=1; frames_ok unchanged.
- Assert badframe on the eof byte of a 4-byte frame -> out_err=1 on the eof word. Pulse app_rst_n low mid-frame -> all outputs 0 and the FSM returns to IDLE.
